// File: rtl/jtpang_vtiming_pkg.sv
// Default timing profiles (Pang and a generic 256-line raster) and the irq_din field layout.
// Positions are 9-bit counts; anything above 511 does not fit the counters.
package jtpang_vtiming_pkg;

    // Pang profile
    localparam int PANG_HCNT_END = 511;
    localparam int PANG_HB_START = 457;
    localparam int PANG_HB_END   = 74;
    localparam int PANG_HS_START = 495;
    localparam int PANG_HS_LEN   = 32;
    localparam int PANG_VCNT_END = 271;
    localparam int PANG_VB_START = 247;
    localparam int PANG_VB_END   = 7;
    localparam int PANG_VS_START = 263;
    localparam int PANG_VS_LEN   = 3;

    // 256-line profile
    localparam int V256_VCNT_END = 255;
    localparam int V256_VB_START = 240;
    localparam int V256_VB_END   = 16;
    localparam int V256_VS_START = 244;
    localparam int V256_VS_LEN   = 3;

    // irq_din = {enable, line[8:0]}
    localparam int IRQ_EN_BIT   = 9;
    localparam int IRQ_LINE_MSB = 8;

    function automatic logic [8:0] wrap_pos(input int pos, input int last);
        return 9'(pos % (last + 1));
    endfunction

endpackage

// File: rtl/jtpang_vtiming_cen.sv
// Fractional clock enable: pulses pxl2_cen at clk*CEN_N/CEN_M with at most one clk of jitter.
// tick is the combinational wrap flag, i.e. pxl2_cen one clk early.
module jtpang_vtiming_cen #(
    parameter int CEN_N = 1,
    parameter int CEN_M = 3,
    parameter int CW    = 4
) (
    input  logic clk,
    input  logic rst,
    output logic tick,
    output logic pxl2_cen
);

    logic [CW-1:0] acc;
    logic [CW:0]   sum;

    assign sum  = {1'b0, acc} + (CW+1)'(CEN_N);
    assign tick = (sum >= (CW+1)'(CEN_M));

    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= '0;
            pxl2_cen <= 1'b0;
        end else begin
            pxl2_cen <= tick;
            acc      <= tick ? CW'(sum - (CW+1)'(CEN_M)) : sum[CW-1:0];
        end
    end

endmodule

// File: rtl/jtpang_vtiming.sv
// Video timing generator (H/V counters, blanking/sync strobes) with IRQN raster line interrupts.
// Strobes are refreshed the clk after each pixel step, so they always describe the current h/v.
module jtpang_vtiming
    import jtpang_vtiming_pkg::*;
#(
    parameter int CEN_N    = 1,
    parameter int CEN_M    = 3,
    parameter int CW       = 4,
    parameter int HCNT_END = PANG_HCNT_END,
    parameter int HB_START = PANG_HB_START,
    parameter int HB_END   = PANG_HB_END,
    parameter int HS_START = PANG_HS_START,
    parameter int HS_LEN   = PANG_HS_LEN,
    parameter int VCNT_END = PANG_VCNT_END,
    parameter int VB_START = PANG_VB_START,
    parameter int VB_END   = PANG_VB_END,
    parameter int VS_START = PANG_VS_START,
    parameter int VS_LEN   = PANG_VS_LEN,
    parameter int IRQN     = 2,
    parameter int IRQ_H    = 0,
    parameter int VCMP_RST = 248
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flip,
    output logic            pxl2_cen,
    output logic            pxl_cen,
    output logic [8:0]      h,
    output logic [8:0]      v,
    output logic [8:0]      hf,
    output logic [7:0]      vf,
    output logic            LHBL,
    output logic            LVBL,
    output logic            HS,
    output logic            VS,
    output logic            Hinit,
    output logic            Vinit,
    input  logic            irq_we,
    input  logic [3:0]      irq_sel,
    input  logic [9:0]      irq_din,
    input  logic [IRQN-1:0] irq_ack,
    output logic [IRQN-1:0] irq_pend,
    output logic            int_n
);

    localparam logic [8:0] H_END   = 9'(HCNT_END);
    localparam logic [8:0] V_END   = 9'(VCNT_END);
    localparam logic [8:0] HB_S    = 9'(HB_START);
    localparam logic [8:0] HB_E    = 9'(HB_END);
    localparam logic [8:0] VB_S    = 9'(VB_START);
    localparam logic [8:0] VB_E    = 9'(VB_END);
    localparam logic [8:0] HS_S    = 9'(HS_START);
    localparam logic [8:0] HS_STOP = wrap_pos(HS_START + HS_LEN, HCNT_END);
    localparam logic [8:0] VS_S    = 9'(VS_START);
    localparam logic [8:0] VS_STOP = wrap_pos(VS_START + VS_LEN, VCNT_END);
    localparam logic [8:0] IRQ_HP  = 9'(IRQ_H);
    localparam logic [8:0] CMP_RST = 9'(VCMP_RST);

    logic            tick;
    logic            phase;
    logic            upd;
    logic [8:0]      cmp [IRQN];
    logic [IRQN-1:0] en;
    logic [IRQN-1:0] pend;
    logic [IRQN-1:0] hit;

    jtpang_vtiming_cen #(
        .CEN_N (CEN_N),
        .CEN_M (CEN_M),
        .CW    (CW)
    ) u_cen (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .pxl2_cen (pxl2_cen)
    );

    assign hf       = h ^ {9{flip}};
    assign vf       = v[7:0] ^ {8{flip}};
    assign irq_pend = pend;

    // pxl_cen rides on every second pxl2_cen; upd is the clk after the count step
    always_ff @(posedge clk) begin
        if (rst) begin
            phase   <= 1'b0;
            pxl_cen <= 1'b0;
            upd     <= 1'b0;
            h       <= '0;
            v       <= '0;
            LHBL    <= 1'b0;
            LVBL    <= 1'b0;
            HS      <= 1'b0;
            VS      <= 1'b0;
            Hinit   <= 1'b0;
            Vinit   <= 1'b0;
        end else begin
            phase   <= phase ^ tick;
            pxl_cen <= tick & phase;
            upd     <= pxl_cen;
            Hinit   <= upd && (h == '0);
            Vinit   <= upd && (h == '0) && (v == '0);
            if (pxl_cen) begin
                if (h == H_END) begin
                    h <= '0;
                    v <= (v == V_END) ? '0 : v + 9'd1;
                end else begin
                    h <= h + 9'd1;
                end
            end
            if (upd) begin
                if (h == HB_S)      LHBL <= 1'b0;
                else if (h == HB_E) LHBL <= 1'b1;
                if (h == HB_S) begin
                    if (v == VB_S)      LVBL <= 1'b0;
                    else if (v == VB_E) LVBL <= 1'b1;
                end
                if (h == HS_S)         HS <= 1'b1;
                else if (h == HS_STOP) HS <= 1'b0;
                if (h == HS_S) begin
                    if (v == VS_S)         VS <= 1'b1;
                    else if (v == VS_STOP) VS <= 1'b0;
                end
            end
        end
    end

    // Line match uses the registered compare, so a same-clk write takes effect afterwards
    always_comb begin
        hit = '0;
        for (int k = 0; k < IRQN; k++) begin
            if (pxl_cen && (h == IRQ_HP) && (v == cmp[k])) hit[k] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < IRQN; k++) cmp[k] <= CMP_RST;
            en    <= '0;
            pend  <= '0;
            int_n <= 1'b1;
        end else begin
            for (int k = 0; k < IRQN; k++) begin
                if (irq_we && (irq_sel == 4'(k))) begin
                    en[k]  <= irq_din[IRQ_EN_BIT];
                    cmp[k] <= irq_din[IRQ_LINE_MSB:0];
                end
            end
            pend  <= hit | (pend & ~irq_ack);
            int_n <= ~|(pend & en);
        end
    end

endmodule

// File: doc/jtpang_vtiming.md
Name: jtpang_vtiming

Overview:
Parametrised video timing generator and raster interrupt controller for the video subsystem.
- Derives pxl2_cen/pxl_cen from the system clock with a fractional enable.
- Runs H/V counters and produces blanking/sync strobes plus flipped counters.
- Raises CPU interrupts from IRQN programmable line comparators.
- Replaces fixed-constant timing and hard-wired int_n decoding, so one block serves every board variant.

Parameters:
- CEN_N, 1, fractional enable numerator (pxl2_cen rate = clk·N/M).
- CEN_M, 3, fractional enable denominator; must be > CEN_N.
- CW, 4, accumulator width; must satisfy CEN_M < 2^CW.
- HCNT_END, 511, last H count.
- HB_START, 457, H where LHBL falls.
- HB_END, 74, H where LHBL rises.
- HS_START, 495, H where HS rises.
- HS_LEN, 32, HS width in pixels.
- VCNT_END, 271, last V count.
- VB_START, 247, V where LVBL falls.
- VB_END, 7, V where LVBL rises.
- VS_START, 263, V where VS rises.
- VS_LEN, 3, VS width in lines.
- IRQN, 2, number of line-interrupt channels (1..8).
- IRQ_H, 0, H position at which line compares are evaluated.
- VCMP_RST, 248, reset value of every compare register.

Ports:
- clk, in, 1, system clock (48 MHz).
- rst, in, 1, synchronous active-high reset.
- flip, in, 1, screen flip.
- pxl2_cen, out, 1, 2× pixel enable.
- pxl_cen, out, 1, pixel enable.
- h, out, 9, H count.
- v, out, 9, V count.
- hf, out, 9, h XOR {9{flip}}.
- vf, out, 8, v[7:0] XOR {8{flip}}.
- LHBL, out, 1, horizontal blank, active low.
- LVBL, out, 1, vertical blank, active low.
- HS, out, 1, horizontal sync.
- VS, out, 1, vertical sync.
- Hinit, out, 1, one-clk pulse at h==0.
- Vinit, out, 1, one-clk pulse at h==0, v==0.
- irq_we, in, 1, write strobe for the comparator register file.
- irq_sel, in, 4, target channel for a write (the whole 4-bit field is decoded).
- irq_din, in, 10, {enable, line[8:0]}.
- irq_ack, in, IRQN, per-channel pending clear, one-hot or multi-hot.
- irq_pend, out, IRQN, pending flags.
- int_n, out, 1, active-low OR of (pending & enable).

Behaviour:
Clock, reset and polarity:
- One clock (clk); reset rst is synchronous and active-high.
- Reset values: acc=0, pxl2_cen=0, pxl_cen=0, h=0, v=0, LHBL=0, LVBL=0, HS=0, VS=0, Hinit=0, Vinit=0, pending=0, enables=0, compares=VCMP_RST, int_n=1.
- Reset mid-frame restarts counters at 0,0 on the next clk with no partial pulses.

Fractional enable:
- Every clk, acc += CEN_N.
- If (acc+CEN_N) >= CEN_M, then acc = acc+CEN_N-CEN_M and pxl2_cen=1 for one clk.
- pxl_cen asserts on every second pxl2_cen, starting with the second pxl2_cen after reset.
- Defaults give exactly 16/8 MHz with no jitter beyond ±1 clk.

Counters (advance only on pxl_cen):
- h wraps HCNT_END→0.
- v increments when h wraps, and wraps VCNT_END→0.
- Widths are 9 bits; parameters above 511 are illegal.

Strobes (registered, updated on pxl_cen, valid the clk after the count change):
- LHBL falls at h==HB_START and rises at h==HB_END; wrap-around intervals are legal.
- LVBL is updated only at h==HB_START: falls when v==VB_START, rises when v==VB_END.
- HS is high for h in HS_START..HS_START+HS_LEN-1, taken modulo HCNT_END+1.
- VS is updated at h==HS_START and is high for VS_LEN lines starting at VS_START, modulo VCNT_END+1.
- hf and vf are combinational from the h/v registers.

Line interrupts:
- On pxl_cen with h==IRQ_H, every channel k with v==cmp[k] sets pend[k]. Comparison runs regardless of enable.
- irq_ack[k] clears pend[k] the next clk. Same-clk set and ack: set wins.
- irq_we writes channel irq_sel (enable, cmp), effective the next clk.
- Writing the channel whose line matches in the same clk uses the old compare value.
- irq_sel >= IRQN is ignored.
- int_n is registered: int_n = ~|(pend & en), updated each clk.
- Disabling a pending channel deasserts int_n without clearing pend.

Decomposition:
- Package jtpang_vtiming_pkg holds the default timing constants (Pang and a 256-line profile) and the irq_din field offsets.
- Sub-module jtpang_vtiming_cen contains the fractional accumulator only.
- Counters, strobes and the IRQ register file stay in the top module.

Test Plan:
1. Defaults, rst held 5 clk then released → pxl2_cen every 3 clk, pxl_cen every 6 clk; a line is 512 pxl_cen; a frame is 272 lines.
2. Blanking at defaults → LHBL low for h 457..511 and 0..73 (129 pixels); LVBL low for v 247..271 and 0..6 (32 lines); HS 32 pixels from h=495.
3. Write ch0 {1,9'd100}, ch1 {1,9'd200} → pend=01 at v=100, h=0; int_n=0 next clk; ack 01 → int_n=1; pend=10 at v=200.
4. Same-clk irq_ack[0] and match on ch0 → pend[0] stays 1; int_n remains 0.
5. flip=1 with h=5, v=10 → hf=506, vf=245; flip=0 → hf=5, vf=10.
6. Assert rst at v=150 with pend=11 → next clk h=0, v=0, pend=00, int_n=1, compares=248; CEN_N=2, CEN_M=5 build → 2 pxl2_cen per 5 clk.
